mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 39 +++
 rtl/mem_arbiter.sv | 120 ++++++++++++
 tb/tb_mem_arbiter.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Request/response bundle between the fetch port, the data port, the arbiter and the shared memory.
// master = arbiter side, slave = requesters plus memory.
interface mem_arbiter_if #(
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [DATA_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ready;

  logic              dm_req;
  logic              dm_we;
  logic [DATA_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_ready;

  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  logic              stall;
  logic              err;

  modport master (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
    output if_rdata, if_ready, dm_rdata, dm_ready,
    output mem_req, mem_we, mem_addr, mem_wdata, stall, err
  );

  modport slave (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
    input  if_rdata, if_ready, dm_rdata, dm_ready,
    input  mem_req, mem_we, mem_addr, mem_wdata, stall, err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto one memory; data has priority with a bounded burst. ARB_TIMEOUT_EN adds an ack watchdog.
// Latency: req at N, mem_req at N+1, ready at ack+1 (min N+2); requesters are held off by stall until their ready pulse.
module mem_arbiter #(
  parameter int DATA_W       = 32,
  parameter int DM_BURST_MAX = 4,
  parameter int TIMEOUT      = 15
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.master bus
);
  typedef enum logic [1:0] {IDLE, IF_BUSY, DM_BUSY} state_t;

  localparam int             BURST_W   = $clog2(DM_BURST_MAX + 1);
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(DM_BURST_MAX);

  state_t             state;
  logic [BURST_W-1:0] burst_cnt;
  logic               if_ok;
  logic               dm_ok;
  logic               if_win;
  logic               dm_win;
  logic               wd_fire;

  // A port whose ready is high this cycle is presenting a stale request.
  assign if_ok  = bus.if_req & ~bus.if_ready;
  assign dm_ok  = bus.dm_req & ~bus.dm_ready;
  // While the data port still asserts req (even in its ready cycle) it keeps priority until the burst saturates.
  assign if_win = if_ok & ((burst_cnt == BURST_MAX) | ~bus.dm_req);
  assign dm_win = dm_ok & ~if_win;

  assign bus.stall = (bus.if_req & ~bus.if_ready) | (bus.dm_req & ~bus.dm_ready);

`ifdef ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_cnt;

  assign wd_fire = (state != IDLE) && !bus.mem_ack && (wd_cnt == WD_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt <= '0;
    end else if (state == IDLE || bus.mem_ack || wd_fire) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end
`else
  localparam int unused_timeout = TIMEOUT;
  assign wd_fire = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      burst_cnt     <= '0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= {DATA_W{1'b0}};
      bus.mem_wdata <= {DATA_W{1'b0}};
      bus.if_ready  <= 1'b0;
      bus.dm_ready  <= 1'b0;
      bus.if_rdata  <= {DATA_W{1'b0}};
      bus.dm_rdata  <= {DATA_W{1'b0}};
      bus.err       <= 1'b0;
    end else begin
      bus.if_ready <= 1'b0;
      bus.dm_ready <= 1'b0;
      bus.err      <= wd_fire;
      case (state)
        IDLE: begin
          if (if_win) begin
            state        <= IF_BUSY;
            bus.mem_req  <= 1'b1;
            bus.mem_we   <= 1'b0;
            bus.mem_addr <= bus.if_addr;
            burst_cnt    <= '0;
          end else if (dm_win) begin
            state         <= DM_BUSY;
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= bus.dm_we;
            bus.mem_addr  <= bus.dm_addr;
            bus.mem_wdata <= bus.dm_wdata;
            if (!bus.if_req) begin
              burst_cnt <= '0;
            end else if (burst_cnt != BURST_MAX) begin
              burst_cnt <= burst_cnt + 1'b1;
            end
          end else if (!bus.if_req) begin
            burst_cnt <= '0;
          end
        end
        IF_BUSY: begin
          if (bus.mem_ack || wd_fire) begin
            state        <= IDLE;
            bus.mem_req  <= 1'b0;
            bus.if_ready <= 1'b1;
            bus.if_rdata <= bus.mem_ack ? bus.mem_rdata : {DATA_W{1'b0}};
          end
        end
        DM_BUSY: begin
          if (bus.mem_ack || wd_fire) begin
            state        <= IDLE;
            bus.mem_req  <= 1'b0;
            bus.dm_ready <= 1'b1;
            // Stores leave the last load value visible.
            if (!bus.mem_we) begin
              bus.dm_rdata <= bus.mem_ack ? bus.mem_rdata : {DATA_W{1'b0}};
            end
          end
        end
        default: begin
          state       <= IDLE;
          bus.mem_req <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, load latency, collision, starvation, idle ack, stall, timeout, reset.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  mem_arbiter_if #(.DATA_W(32)) bus ();

  mem_arbiter #(
    .DATA_W      (32),
    .DM_BURST_MAX(4),
    .TIMEOUT     (15)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  int   n_grants;
  int   busy;
  logic done;
  logic err_seen;
  logic [31:0] rd_seen;
  logic grant_if [6];
  logic exp_if   [6];

  initial begin
    exp_if = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    rst = 1'b1;
    bus.if_req = 1'b0;  bus.if_addr = '0;
    bus.dm_req = 1'b0;  bus.dm_we = 1'b0;  bus.dm_addr = '0;  bus.dm_wdata = '0;
    bus.mem_rdata = '0; bus.mem_ack = 1'b0;
    tick(); tick();

    // Reset state
    check("rst_mem_req",   bus.mem_req,   0);
    check("rst_mem_we",    bus.mem_we,    0);
    check("rst_mem_addr",  bus.mem_addr,  0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    check("rst_if_ready",  bus.if_ready,  0);
    check("rst_dm_ready",  bus.dm_ready,  0);
    check("rst_if_rdata",  bus.if_rdata,  0);
    check("rst_dm_rdata",  bus.dm_rdata,  0);
    check("rst_err",       bus.err,       0);
    check("rst_stall",     bus.stall,     0);
    rst = 1'b0;
    tick();

    // Single fetch, ack two cycles after mem_req
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    tick();
    check("fetch_mem_req",  bus.mem_req,  1);
    check("fetch_mem_we",   bus.mem_we,   0);
    check("fetch_mem_addr", bus.mem_addr, 32'h100);
    tick();
    check("fetch_wait_req",   bus.mem_req,  1);
    check("fetch_wait_ready", bus.if_ready, 0);
    check("fetch_wait_stall", bus.stall,    1);
    tick();
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h2008_0005;
    check("fetch_ack_we", bus.mem_we, 0);
    tick();
    bus.mem_ack = 1'b0;
    check("fetch_ready",   bus.if_ready, 1);
    check("fetch_rdata",   bus.if_rdata, 32'h2008_0005);
    check("fetch_done_req", bus.mem_req, 0);
    check("fetch_done_we", bus.mem_we,   0);
    check("fetch_stall0",  bus.stall,    0);
    bus.if_req = 1'b0;
    tick();
    check("fetch_pulse1", bus.if_ready, 0);
    check("fetch_hold",   bus.if_rdata, 32'h2008_0005);

    // Minimum-latency load, requester drops req mid-transaction
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h80;
    tick();
    check("lw_mem_req",  bus.mem_req,  1);
    check("lw_mem_addr", bus.mem_addr, 32'h80);
    check("lw_mem_we",   bus.mem_we,   0);
    bus.dm_req = 1'b0; bus.mem_ack = 1'b1; bus.mem_rdata = 32'h1234_5678;
    tick();
    bus.mem_ack = 1'b0;
    check("lw_ready",    bus.dm_ready, 1);
    check("lw_rdata",    bus.dm_rdata, 32'h1234_5678);
    check("lw_mem_req0", bus.mem_req,  0);
    tick();
    check("lw_pulse1", bus.dm_ready, 0);

    // Collision: store wins, fetch follows, dm_rdata untouched by the store
    bus.if_req = 1'b1; bus.if_addr = 32'h200;
    bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 32'h40; bus.dm_wdata = 32'hDEAD_BEEF;
    tick();
    check("col_dm_we",    bus.mem_we,    1);
    check("col_dm_addr",  bus.mem_addr,  32'h40);
    check("col_dm_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'hBAD0_BAD0;
    tick();
    bus.mem_ack = 1'b0;
    check("col_dm_ready", bus.dm_ready, 1);
    check("col_dm_rdata", bus.dm_rdata, 32'h1234_5678);
    bus.dm_req = 1'b0;
    tick();
    check("col_if_req",  bus.mem_req,  1);
    check("col_if_we",   bus.mem_we,   0);
    check("col_if_addr", bus.mem_addr, 32'h200);
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'hCAFE_F00D;
    tick();
    bus.mem_ack = 1'b0;
    check("col_if_ready", bus.if_ready, 1);
    check("col_if_rdata", bus.if_rdata, 32'hCAFE_F00D);
    bus.if_req = 1'b0;
    tick();

    // Starvation guard: both ports held, memory acks every busy cycle
    bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 32'h300; bus.dm_wdata = 32'h11;
    bus.if_req = 1'b1; bus.if_addr = 32'h400;
    n_grants = 0;
    for (int c = 0; c < 40 && n_grants < 6; c++) begin
      tick();
      bus.mem_ack = bus.mem_req;
      if (bus.mem_req) begin
        grant_if[n_grants] = !bus.mem_we;
        n_grants++;
      end
    end
    check("starve_grants", n_grants, 6);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("starve_grant%0d_is_if", i), {31'd0, grant_if[i]}, {31'd0, exp_if[i]});
    end
    bus.dm_req = 1'b0; bus.if_req = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      bus.mem_ack = bus.mem_req;
    end
    tick();
    bus.mem_ack = 1'b0;

    // Stray ack in IDLE does nothing
    tick();
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'hFFFF_FFFF;
    tick();
    bus.mem_ack = 1'b0;
    check("idle_ack_if_ready", bus.if_ready, 0);
    check("idle_ack_dm_ready", bus.dm_ready, 0);
    check("idle_ack_mem_req",  bus.mem_req,  0);
    check("idle_ack_dm_rdata", bus.dm_rdata, 32'h1234_5678);
    check("idle_ack_if_rdata", bus.if_rdata, 32'hCAFE_F00D);
    tick();

    // Stall follows dm_req until the ready pulse
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h500;
    #1 check("stall_c0", bus.stall, 1);
    tick();
    check("stall_c1", bus.stall, 1);
    tick();
    check("stall_c2", bus.stall, 1);
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h55AA_55AA;
    tick();
    bus.mem_ack = 1'b0;
    check("stall_ready", bus.dm_ready, 1);
    check("stall_pulse", bus.stall,    0);
    check("stall_rdata", bus.dm_rdata, 32'h55AA_55AA);
    bus.dm_req = 1'b0;
    tick();

    // Load that never gets an ack
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h600;
    busy = 0; done = 1'b0; err_seen = 1'b0; rd_seen = '0;
    for (int c = 0; c < 20; c++) begin
      tick();
      bus.dm_req = 1'b0;
      if (bus.mem_req) busy++;
      if (bus.dm_ready && !done) begin
        done = 1'b1; err_seen = bus.err; rd_seen = bus.dm_rdata;
      end
    end
`ifdef ARB_TIMEOUT_EN
    check("to_busy_cycles", busy, 15);
    check("to_ready",       {31'd0, done},     1);
    check("to_err",         {31'd0, err_seen}, 1);
    check("to_rdata",       rd_seen, 0);
    check("to_idle",        bus.mem_req, 0);
`else
    check("nto_busy_cycles", busy, 20);
    check("nto_no_ready",    {31'd0, done}, 0);
    check("nto_mem_req",     bus.mem_req, 1);
    check("nto_err",         bus.err, 0);
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h77;
    tick();
    bus.mem_ack = 1'b0;
    check("nto_late_ready", bus.dm_ready, 1);
    check("nto_late_rdata", bus.dm_rdata, 32'h77);
`endif
    tick();

    // Reset in the middle of a store
    bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 32'h700; bus.dm_wdata = 32'h99;
    tick();
    check("mid_rst_busy", bus.mem_req, 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_mem_req",   bus.mem_req,   0);
    check("mid_rst_mem_we",    bus.mem_we,    0);
    check("mid_rst_mem_addr",  bus.mem_addr,  0);
    check("mid_rst_mem_wdata", bus.mem_wdata, 0);
    check("mid_rst_dm_rdata",  bus.dm_rdata,  0);
    check("mid_rst_if_rdata",  bus.if_rdata,  0);
    check("mid_rst_dm_ready",  bus.dm_ready,  0);
    bus.dm_req = 1'b0;
    tick();
    check("in_rst_dm_ready", bus.dm_ready, 0);
    rst = 1'b0;
    bus.if_req = 1'b1; bus.if_addr = 32'h800;
    tick();
    check("post_rst_grant", bus.mem_req,  1);
    check("post_rst_addr",  bus.mem_addr, 32'h800);
    check("post_rst_no_dm", bus.dm_ready, 0);
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'hABC;
    tick();
    bus.mem_ack = 1'b0; bus.if_req = 1'b0;
    check("post_rst_if_ready", bus.if_ready, 1);
    check("post_rst_if_rdata", bus.if_rdata, 32'hABC);
    check("post_rst_dm_ready", bus.dm_ready, 0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
